// File: rtl/io_pmp_pkg.sv
// Shared types and constants for the IO-PMP configuration controller.
// Optional drain timeout lives in io_pmp_cfg_ctrl behind IO_PMP_CFG_DRAIN_TIMEOUT_EN.
package io_pmp_pkg;

    localparam int unsigned PMPCFG_W           = 8;
    localparam int unsigned NR_ENTRIES_DEFAULT = 16;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        TOR   = 2'd1,
        NA4   = 2'd2,
        NAPOT = 2'd3
    } pmp_mode_e;

    typedef struct packed {
        logic       locked;
        logic [1:0] reserved;
        pmp_mode_e  mode;
        logic       x;
        logic       w;
        logic       r;
    } pmpcfg_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        COMMIT = 2'd2
    } cfg_state_e;

    // Reserved bits read as zero; W without R is a reserved encoding and drops W.
    function automatic pmpcfg_t legalize_cfg(input logic [PMPCFG_W-1:0] raw);
        pmpcfg_t c;
        c          = pmpcfg_t'(raw);
        c.reserved = 2'b00;
        if (c.w && !c.r) begin
            c.w = 1'b0;
        end
        return c;
    endfunction

endpackage

// File: rtl/io_pmp_lock_check.sv
// Combinational lock lookup on the active PMP set for one cfg/addr field.
// Part of io_pmp_cfg_ctrl (optional feature macro: IO_PMP_CFG_DRAIN_TIMEOUT_EN, unused here).
module io_pmp_lock_check
    import io_pmp_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = NR_ENTRIES_DEFAULT,
    parameter int unsigned IDX_WIDTH  = $clog2(NR_ENTRIES)
) (
    input  logic [NR_ENTRIES*PMPCFG_W-1:0] active_cfg_i,
    input  logic [IDX_WIDTH-1:0]           idx_i,
    input  logic                           sel_i,
    output logic                           field_locked_o
);

    pmpcfg_t [NR_ENTRIES-1:0] cfg;
    logic    [NR_ENTRIES-1:0] cfg_lock;
    logic    [NR_ENTRIES-1:0] addr_lock;
    logic                     unused_cfg_fields;

    assign cfg               = active_cfg_i;
    assign unused_cfg_fields = ^cfg;

    for (genvar i = 0; i < NR_ENTRIES; i++) begin : g_lock
        assign cfg_lock[i] = cfg[i].locked;
        // A locked TOR entry also freezes the base address held in the entry below it.
        if (i + 1 < NR_ENTRIES) begin : g_tor
            assign addr_lock[i] = cfg[i].locked |
                                  (cfg[i+1].locked & (cfg[i+1].mode == TOR));
        end else begin : g_last
            assign addr_lock[i] = cfg[i].locked;
        end
    end

    always_comb begin
        field_locked_o = 1'b0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            if (32'(idx_i) == i) begin
                field_locked_o = sel_i ? cfg_lock[i] : addr_lock[i];
            end
        end
    end

endmodule

// File: rtl/io_pmp_cfg_ctrl.sv
// Shadow/active PMP configuration with drain-then-commit atomic update.
// Optional drain timeout abort enabled by defining IO_PMP_CFG_DRAIN_TIMEOUT_EN.
module io_pmp_cfg_ctrl
    import io_pmp_pkg::*;
#(
    parameter int unsigned NR_ENTRIES    = NR_ENTRIES_DEFAULT,
    parameter int unsigned ADDR_WIDTH    = 64,
    parameter int unsigned IDX_WIDTH     = $clog2(NR_ENTRIES),
    parameter int unsigned DRAIN_TIMEOUT = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfg_req_i,
    input  logic                             cfg_we_i,
    input  logic                             cfg_sel_i,
    input  logic [IDX_WIDTH-1:0]             cfg_idx_i,
    input  logic [ADDR_WIDTH-1:0]            cfg_wdata_i,
    output logic                             cfg_gnt_o,
    output logic                             cfg_rvalid_o,
    output logic [ADDR_WIDTH-1:0]            cfg_rdata_o,
    output logic                             cfg_err_o,
    input  logic                             commit_i,
    output logic                             commit_done_o,
    output logic                             commit_err_o,
    input  logic                             pmp_busy_i,
    output logic                             stall_o,
    output logic [NR_ENTRIES*ADDR_WIDTH-1:0] pmp_addr_o,
    output logic [NR_ENTRIES*PMPCFG_W-1:0]   pmp_cfg_o
);

    cfg_state_e state_q, state_d;

    logic    [NR_ENTRIES-1:0][ADDR_WIDTH-1:0] shadow_addr_q, active_addr_q;
    pmpcfg_t [NR_ENTRIES-1:0]                 shadow_cfg_q, active_cfg_q;

    logic                  rvalid_q, err_q, err_d;
    logic [ADDR_WIDTH-1:0] rdata_q, rdata_d;
    logic                  done_q, done_d;
    logic                  gnt, idx_ok, field_locked, wr_en, apply;
    logic                  timeout_hit;

    assign idx_ok = 32'(cfg_idx_i) < NR_ENTRIES;
    assign gnt    = cfg_req_i && (state_q == IDLE);
    assign wr_en  = gnt && cfg_we_i && idx_ok && !field_locked;

    io_pmp_lock_check #(
        .NR_ENTRIES(NR_ENTRIES),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_lock_check (
        .active_cfg_i  (active_cfg_q),
        .idx_i         (cfg_idx_i),
        .sel_i         (cfg_sel_i),
        .field_locked_o(field_locked)
    );

    always_comb begin
        rdata_d = '0;
        err_d   = gnt && (!idx_ok || (cfg_we_i && field_locked));
        if (gnt && !cfg_we_i && idx_ok) begin
            rdata_d = cfg_sel_i ? ADDR_WIDTH'(shadow_cfg_q[cfg_idx_i])
                                : shadow_addr_q[cfg_idx_i];
        end
    end

`ifdef IO_PMP_CFG_DRAIN_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CntW-1:0] TimeoutVal = CntW'(DRAIN_TIMEOUT);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            cerr_q;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (state_q == DRAIN) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign timeout_hit = (state_q == DRAIN) && pmp_busy_i && (cnt_d == TimeoutVal);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            cerr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            cerr_q <= timeout_hit;
        end
    end

    assign commit_err_o = cerr_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^DRAIN_TIMEOUT;
    assign timeout_hit    = 1'b0;
    assign commit_err_o   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        apply   = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (commit_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!pmp_busy_i) begin
                    state_d = COMMIT;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            COMMIT: begin
                apply   = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= gnt;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_addr_q <= '0;
            shadow_cfg_q  <= '0;
        end else if (wr_en) begin
            if (cfg_sel_i) begin
                shadow_cfg_q[cfg_idx_i] <= legalize_cfg(cfg_wdata_i[PMPCFG_W-1:0]);
            end else begin
                shadow_addr_q[cfg_idx_i] <= cfg_wdata_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_addr_q <= '0;
            active_cfg_q  <= '0;
        end else if (apply) begin
            active_addr_q <= shadow_addr_q;
            active_cfg_q  <= shadow_cfg_q;
        end
    end

    assign cfg_gnt_o     = gnt;
    assign cfg_rvalid_o  = rvalid_q;
    assign cfg_rdata_o   = rdata_q;
    assign cfg_err_o     = err_q;
    assign commit_done_o = done_q;
    assign stall_o       = (state_q != IDLE);
    assign pmp_addr_o    = active_addr_q;
    assign pmp_cfg_o     = active_cfg_q;

endmodule
